bcd_display_scanner: RTL
========================

Name: bcd_display_scanner

Overview:
- Downstream consumer of the mod-10 counter stages: takes NUM_DIGITS packed BCD digits (one per cascaded mod-10 counter) and drives a time-multiplexed seven-segment display.
- Double-buffers the digit snapshot so the display never tears mid-frame.
- Scans one digit per SCAN_DIV clocks and flags out-of-range BCD codes.

Parameters:
- NUM_DIGITS, 4, number of BCD digits scanned, range 2..8.
- SCAN_DIV, 1000, clock cycles each digit slot is held, minimum 2.
- ACTIVE_LOW, 1, 1 = seg and anode outputs active-low (common-anode panel); 0 = active-high.

Ports:
- clock  in  1  single system clock, rising edge.
- clear  in  1  synchronous active-low reset.
- load  in  1  capture digits into the pending buffer this cycle.
- digits  in  4*NUM_DIGITS  packed BCD; digit 0 = bits [3:0] = least significant, rightmost.
- seg  out  7  segments a..g; bit 0 = a, bit 6 = g.
- anode  out  NUM_DIGITS  one-hot digit enable; bit i selects digit i.
- frame_done  out  1  one-cycle pulse at the end of each full scan.
- bcd_err  out  1  sticky flag: an invalid code (10..15) was displayed.

Behaviour:
- Polarity: "on"/"off" below are logical levels. When ACTIVE_LOW=1, both seg and anode are inverted at the output register.
- Reset, sampled when clear=0 at a clock edge:
  - prescaler=0, index=0, display buffer=0, pending buffer=0, pending_valid=0.
  - seg all off, anode all off, frame_done=0, bcd_err=0.
  - Reset applies mid-frame or mid-load; any pending snapshot is discarded.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick is asserted when prescaler = SCAN_DIV-1.
- Index: advances on tick, 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0.
- Frame boundary: a tick while index = NUM_DIGITS-1.
  - frame_done is registered high for exactly the cycle after the boundary edge.
- Load: when load=1, the pending buffer captures digits and pending_valid is set to 1. Repeated loads overwrite; last load wins.
- Transfer: at a frame boundary with pending_valid=1, the display buffer takes the pending buffer and pending_valid clears.
- Load coincident with a frame boundary:
  - The transfer uses the pending contents held before this edge.
  - The new digits are written to pending and pending_valid stays 1.
  - If pending_valid was 0 before the edge, no transfer occurs, and the new value waits for the next boundary.
- Outputs are registered with one cycle of latency from index/prescaler state.
- Ghost suppression: for the first cycle of every slot (prescaler = 0), anode is all off and seg is off.
  - For the remaining SCAN_DIV-1 cycles, anode = one-hot(index) and seg = decode(display[index]).
- Decode: 0..9 use the standard patterns. Codes 10..15 display a dash (g only) and set bcd_err.
- bcd_err is cleared only by reset.
- Display buffer contents change only at frame boundaries. Digit slots within a frame always come from one snapshot.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - Any digit i > 0 that is zero, where all digits above i are also zero, shows seg off while its anode still scans normally.
  - Digit 0 is never blanked.
  - Blanking is computed from the display buffer, not the pending buffer.
- Undefined: every digit is displayed, including leading zeros. No blanking logic is synthesised.

Decomposition:
- Package bcd_disp_pkg:
  - 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (logical, active-high, bit 0 = a).
  - Function that builds the one-hot anode pattern.
- Sub-module bcd_to_seg7: purely combinational 4-bit code -> 7-bit segments plus invalid flag. One instance, fed by the index mux.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0 unless noted):
- Reset sequence:
  - clear=0 for 3 cycles -> seg=0, anode=0, frame_done=0, bcd_err=0.
  - Release -> first active anode=0001 appears at prescaler=1 of slot 0.
- Load 16'h1234, then wait one boundary:
  - Slots show seg for 4, 3, 2, 1 with anodes 0001, 0010, 0100, 1000, each active 3 of 4 cycles.
  - frame_done pulses once per 16 cycles.
- Load 16'h5678 mid-frame while 16'h1234 is displayed:
  - Rest of the frame still shows 1234.
  - Next frame shows 5678; no mixed frame.
- Load 16'h9999 in the exact boundary cycle with no prior pending:
  - The next frame still shows the old value.
  - The following frame shows 9999.
- Load 16'h00A0 -> digit 1 shows dash (7'b1000000) and bcd_err goes 1. A later load of 16'h0000 leaves bcd_err=1 until clear=0.
- BCD_LEADING_ZERO_BLANK_EN defined, load 16'h0070:
  - Digits 3 and 2 show seg=0 with anodes still scanning.
  - Digit 1 shows 7 and digit 0 shows 0.
  - Repeat with ACTIVE_LOW=1 and check all outputs are inverted.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD seven-segment display scanner.
// Segment patterns are logical (1 = segment lit), bit 0 = a ... bit 6 = g.
package bcd_disp_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Logical one-hot digit enable; callers truncate to their digit count.
  function automatic logic [MAX_DIGITS-1:0] anode_onehot(input int unsigned idx);
    return {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder. Codes 10..15 render as a
// dash and raise invalid so the scanner can latch an error flag.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg,
  output logic       invalid
);

  // Table lookup of the digit pattern, dash for out-of-range codes
  always_comb begin
    // NOTE: every output gets a value before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    seg     = SEG_DASH;
    invalid = 1'b0;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed seven-segment driver for NUM_DIGITS packed BCD digits.
// New digits land in a pending buffer and move to the display buffer only
// at a frame boundary, so a frame never mixes two snapshots.
// Optional: define BCD_LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done,
  output logic                    bcd_err
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  // Output inversion masks for common-anode panels
  localparam logic [6:0]            SEG_POL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_POL  = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0] prescaler;
  logic [IW-1:0] index;
  logic [DW-1:0] display_buf;
  logic [DW-1:0] pending_buf;
  logic          pending_valid;

  logic                  tick;
  logic                  boundary;
  logic [3:0]            cur_code;
  logic [6:0]            dec_seg;
  logic                  dec_invalid;
  logic                  cur_blank;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] anode_next;
  logic                  err_hit;

  assign tick     = (prescaler == PRE_LAST);
  assign boundary = tick && (index == IDX_LAST);
  assign cur_code = display_buf[{index, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .code    (cur_code),
    .seg     (dec_seg),
    .invalid (dec_invalid)
  );

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_mask;

  // Walk down from the top digit while the run of zeros holds; digit 0 is never blanked
  always_comb begin
    logic run;
    run        = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run           = run && (display_buf[4*i +: 4] == 4'd0);
      blank_mask[i] = run;
    end
  end

  assign cur_blank = blank_mask[index];
`else
  assign cur_blank = 1'b0;
`endif

  // Slot timing: prescaler paces each slot, index walks the digits
  always_ff @(posedge clock) begin
    if (!clear) begin
      prescaler <= '0;
      index     <= '0;
    end else if (tick) begin
      prescaler <= '0;
      index     <= (index == IDX_LAST) ? '0 : index + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Double buffer: capture on load, publish to the display only at a frame boundary
  always_ff @(posedge clock) begin
    if (!clear) begin
      // NOTE: the display buffer feeds the outputs directly, so it is reset
      // like any control register rather than left as uninitialised storage.
      display_buf   <= '0;
      pending_buf   <= '0;
      pending_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking updates mean display_buf takes the pending value
      // held before this edge even when load overwrites pending_buf here.
      if (boundary && pending_valid) begin
        display_buf   <= pending_buf;
        pending_valid <= 1'b0;
      end
      if (load) begin
        pending_buf   <= digits;
        pending_valid <= 1'b1;
      end
    end
  end

  // Next output values; the first cycle of every slot is dark to hide ghosting
  always_comb begin
    seg_next   = SEG_OFF;
    anode_next = '0;
    err_hit    = 1'b0;
    if (prescaler != '0) begin
      anode_next = NUM_DIGITS'(anode_onehot(32'(index)));
      seg_next   = cur_blank ? SEG_OFF : dec_seg;
      err_hit    = dec_invalid;
    end
  end

  // Registered outputs with panel polarity applied; bcd_err is sticky until clear
  always_ff @(posedge clock) begin
    if (!clear) begin
      seg        <= SEG_OFF ^ SEG_POL;
      anode      <= AN_POL;
      frame_done <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      seg        <= seg_next ^ SEG_POL;
      anode      <= anode_next ^ AN_POL;
      frame_done <= boundary;
      bcd_err    <= bcd_err | err_hit;
    end
  end

endmodule
